// File: rtl/kgp_branch_pkg.sv
// kgp_branch_pkg: branch type codes, sequencer states and comparison codes
package kgp_branch_pkg;
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_BL   = 3'b010;
  localparam logic [2:0] BR_BR   = 3'b011;
  localparam logic [2:0] BR_BZ   = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BNZ  = 3'b110;
  localparam logic [2:0] BR_HALT = 3'b111;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT, S_ERR} state_t;
  localparam logic [1:0] CMP_BZ   = 2'b00;
  localparam logic [1:0] CMP_BLTZ = 2'b01;
  localparam logic [1:0] CMP_BNZ  = 2'b10;
  function automatic logic [1:0] cmp_code(input logic [2:0] t);
    return t == BR_BLTZ ? CMP_BLTZ : t == BR_BNZ ? CMP_BNZ : CMP_BZ;
  endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: decides whether a comparison branch is taken from ALU flags
module branch_cond_eval
  import kgp_branch_pkg::*;
(
  input  logic [1:0] cmp,
  input  logic       zero,
  input  logic       msb,
  output logic       taken
);
  // unknown codes never redirect
  always_comb taken = cmp == CMP_BZ ? zero : cmp == CMP_BLTZ ? msb : cmp == CMP_BNZ ? !zero : 1'b0;
endmodule

// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: program counter and control-transfer sequencing for the KGP-RISC core
module branch_pc_sequencer
  import kgp_branch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                OFF_W    = 22,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [2:0]        br_type,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0] rs_value,
  input  logic              alu_valid,
  input  logic              alu_zero,
  input  logic              alu_msb,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              halted,
  output logic              err_timeout,
  output logic [15:0]       taken_cnt
);
  state_t            state;
  logic [ADDR_W-1:0] seq, tgt, tgt_q;
  logic [1:0]        cmp_q;
  logic [3:0]        wait_cnt;
  logic [15:0]       cnt_inc;
  logic              taken, is_cmp;
  branch_cond_eval u_cond (.cmp(cmp_q), .zero(alu_zero), .msb(alu_msb), .taken(taken));
  // next sequential address, word-offset target and saturating taken count
  always_comb begin
    seq     = pc + ADDR_W'(4);
    tgt     = seq + ({{(ADDR_W-OFF_W){br_offset[OFF_W-1]}}, br_offset} << 2);
    is_cmp  = br_type == BR_BZ || br_type == BR_BLTZ || br_type == BR_BNZ;
    cnt_inc = taken_cnt == 16'hFFFF ? taken_cnt : taken_cnt + 16'd1;
    stall   = state != S_RUN || (instr_valid && is_cmp);
  end
  // control FSM: pc update, redirect pulses, wait timeout and branch counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      tgt_q       <= '0;
      cmp_q       <= CMP_BZ;
      wait_cnt    <= '0;
      flush       <= 1'b0;
      link_we     <= 1'b0;
      link_data   <= '0;
      halted      <= 1'b0;
      err_timeout <= 1'b0;
      taken_cnt   <= '0;
    end else begin
      flush   <= 1'b0;
      link_we <= 1'b0;
      case (state)
        S_RUN: if (instr_valid) begin
          case (br_type)
            BR_NONE: pc <= seq;
            BR_B, BR_BL: begin
              pc        <= tgt;
              flush     <= 1'b1;
              taken_cnt <= cnt_inc;
              link_we   <= br_type == BR_BL;
              link_data <= br_type == BR_BL ? seq : link_data;
            end
            BR_BR: begin
              pc        <= rs_value & ~ADDR_W'(3);
              flush     <= 1'b1;
              taken_cnt <= cnt_inc;
            end
            BR_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: begin
              cmp_q    <= cmp_code(br_type);
              tgt_q    <= tgt;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          endcase
        end
        S_WAIT: if (alu_valid) begin
          state     <= S_RUN;
          pc        <= taken ? tgt_q : seq;
          flush     <= taken;
          taken_cnt <= taken ? cnt_inc : taken_cnt;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == 4'(TIMEOUT - 1)) begin
            state       <= S_ERR;
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_pc_sequencer.sv
// tb_branch_pc_sequencer: directed checks of the branch/pc sequencer
module tb_branch_pc_sequencer;
  import kgp_branch_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [2:0]  br_type = BR_NONE;
  logic [21:0] br_offset = '0;
  logic [31:0] rs_value = '0;
  logic        alu_valid = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_msb = 1'b0;
  logic [31:0] pc, link_data;
  logic        stall, flush, link_we, halted, err_timeout;
  logic [15:0] taken_cnt;
  int checks = 0;
  int errors = 0;
  branch_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .br_type(br_type),
    .br_offset(br_offset), .rs_value(rs_value), .alu_valid(alu_valid),
    .alu_zero(alu_zero), .alu_msb(alu_msb), .pc(pc), .stall(stall), .flush(flush),
    .link_we(link_we), .link_data(link_data), .halted(halted),
    .err_timeout(err_timeout), .taken_cnt(taken_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] t, input logic [21:0] off);
    instr_valid = v;
    br_type     = t;
    br_offset   = off;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_link_we", {31'b0, link_we}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_err", {31'b0, err_timeout}, 32'h0);
    chk("rst_cnt", {16'b0, taken_cnt}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, BR_NONE, '0);
    tick();
    chk("seq_pc4", pc, 32'h4);
    tick();
    chk("seq_pc8", pc, 32'h8);
    tick();
    chk("seq_pc12", pc, 32'hC);
    chk("seq_stall", {31'b0, stall}, 32'h0);
    chk("seq_flush", {31'b0, flush}, 32'h0);
    rs_value = 32'h103;
    drive(1'b1, BR_BR, '0);
    tick();
    chk("br_pc", pc, 32'h100);
    chk("br_flush", {31'b0, flush}, 32'h1);
    chk("br_link_we", {31'b0, link_we}, 32'h0);
    drive(1'b1, BR_BL, 22'd3);
    tick();
    chk("bl_pc", pc, 32'h110);
    chk("bl_link_we", {31'b0, link_we}, 32'h1);
    chk("bl_link_data", link_data, 32'h104);
    chk("bl_flush", {31'b0, flush}, 32'h1);
    chk("bl_cnt", {16'b0, taken_cnt}, 32'h2);
    drive(1'b0, BR_NONE, '0);
    tick();
    chk("idle_pc", pc, 32'h110);
    chk("idle_flush", {31'b0, flush}, 32'h0);
    chk("idle_link_we", {31'b0, link_we}, 32'h0);
    rs_value = 32'h20;
    drive(1'b1, BR_BR, '0);
    tick();
    chk("br20_pc", pc, 32'h20);
    drive(1'b1, BR_BZ, 22'h3FFFFE);
    #1;
    chk("bz_stall_c0", {31'b0, stall}, 32'h1);
    tick();
    drive(1'b1, BR_NONE, '0);
    #1;
    chk("bz_stall_c1", {31'b0, stall}, 32'h1);
    chk("bz_pc_c1", pc, 32'h20);
    tick();
    alu_valid = 1'b1;
    alu_zero  = 1'b1;
    #1;
    chk("bz_stall_c2", {31'b0, stall}, 32'h1);
    chk("bz_flush_c2", {31'b0, flush}, 32'h0);
    tick();
    alu_valid = 1'b0;
    drive(1'b0, BR_NONE, '0);
    #1;
    chk("bz_pc", pc, 32'h1C);
    chk("bz_flush", {31'b0, flush}, 32'h1);
    chk("bz_stall_done", {31'b0, stall}, 32'h0);
    chk("bz_cnt", {16'b0, taken_cnt}, 32'h4);
    do_reset();
    chk("rst2_cnt", {16'b0, taken_cnt}, 32'h0);
    chk("rst2_pc", pc, 32'h0);
    drive(1'b1, BR_BNZ, 22'd5);
    tick();
    drive(1'b0, BR_NONE, '0);
    alu_valid = 1'b1;
    alu_zero  = 1'b1;
    alu_msb   = 1'b0;
    tick();
    alu_valid = 1'b0;
    chk("bnz_pc", pc, 32'h4);
    chk("bnz_flush", {31'b0, flush}, 32'h0);
    drive(1'b1, BR_BLTZ, 22'd1);
    tick();
    drive(1'b0, BR_NONE, '0);
    alu_valid = 1'b1;
    alu_zero  = 1'b0;
    alu_msb   = 1'b1;
    tick();
    alu_valid = 1'b0;
    alu_msb   = 1'b0;
    chk("bltz_pc", pc, 32'hC);
    chk("bltz_flush", {31'b0, flush}, 32'h1);
    chk("bltz_cnt", {16'b0, taken_cnt}, 32'h1);
    drive(1'b1, BR_BZ, 22'd4);
    tick();
    drive(1'b0, BR_NONE, '0);
    for (int i = 0; i < 14; i++) tick();
    chk("edge_stall", {31'b0, stall}, 32'h1);
    chk("edge_err_before", {31'b0, err_timeout}, 32'h0);
    alu_valid = 1'b1;
    alu_zero  = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("edge_pc", pc, 32'h20);
    chk("edge_flush", {31'b0, flush}, 32'h1);
    chk("edge_err", {31'b0, err_timeout}, 32'h0);
    chk("edge_cnt", {16'b0, taken_cnt}, 32'h2);
    drive(1'b1, BR_BZ, 22'd4);
    tick();
    drive(1'b0, BR_NONE, '0);
    for (int i = 0; i < 14; i++) tick();
    chk("to_err_early", {31'b0, err_timeout}, 32'h0);
    tick();
    chk("to_err", {31'b0, err_timeout}, 32'h1);
    chk("to_stall", {31'b0, stall}, 32'h1);
    chk("to_pc", pc, 32'h20);
    alu_valid = 1'b1;
    alu_zero  = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("late_pc", pc, 32'h20);
    chk("late_flush", {31'b0, flush}, 32'h0);
    chk("late_cnt", {16'b0, taken_cnt}, 32'h2);
    chk("late_err", {31'b0, err_timeout}, 32'h1);
    do_reset();
    drive(1'b1, BR_BZ, 22'd4);
    tick();
    drive(1'b0, BR_NONE, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_err", {31'b0, err_timeout}, 32'h0);
    rst_n = 1'b1;
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("post_rst_flush", {31'b0, flush}, 32'h0);
    chk("post_rst_pc", pc, 32'h0);
    drive(1'b1, BR_HALT, '0);
    tick();
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_stall", {31'b0, stall}, 32'h1);
    drive(1'b1, BR_NONE, '0);
    tick();
    tick();
    chk("halt_pc", pc, 32'h0);
    chk("halt_flush", {31'b0, flush}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
